// File: rtl/gray_encoder_tracker_pkg.sv
// Shared state encoding and step-delta constants for the Gray encoder tracker.
package gray_encoder_tracker_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0] DELTA_UP = 4'd1;
    localparam logic [3:0] DELTA_DN = 4'd15;

endpackage

// File: rtl/gray_encoder_tracker_gray2bin4.sv
// Combinational 4-bit Gray-to-binary converter.
module gray2bin4 (
    input  logic [3:0] gray,
    output logic [3:0] bin
);

    assign bin[3] = gray[3];
    assign bin[2] = bin[3] ^ gray[2];
    assign bin[1] = bin[2] ^ gray[1];
    assign bin[0] = bin[1] ^ gray[0];

endmodule

// File: rtl/gray_encoder_tracker.sv
// Gray encoder position tracker: synchronizer, debounce, Gray decode and step/fault FSM.
//
// state    | meaning
// ST_INIT  | waiting for the first accepted code to use as the reference
// ST_TRACK | counting +1/-1 steps against the previously accepted code
// ST_FAULT | illegal jump seen; position frozen until clear
module gray_encoder_tracker
    import gray_encoder_tracker_pkg::*;
#(
    parameter int POS_WIDTH = 8,
    parameter int DEBOUNCE  = 2
) (
    input  logic                 clock,
    input  logic                 reset_b,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [3:0]           gray_in,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 dir,
    output logic                 error,
    output logic                 valid
);

    localparam logic [3:0]           DB_MAX  = 4'(DEBOUNCE);
    localparam logic [3:0]           DB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    logic [3:0] sync1, sync2, cand, cnt;
    logic [3:0] bin, prev, delta;
    logic       accept;
    state_t     state;

    gray2bin4 u_gray2bin4 (
        .gray (cand),
        .bin  (bin)
    );

    // cnt saturates at DEBOUNCE so accept can only fire once per stable code
    assign accept = (sync2 == cand) && (cnt == DB_LAST);
    assign delta  = bin - prev;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
            cand  <= 4'd0;
            cnt   <= 4'd0;
        end else begin
            sync1 <= gray_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= 4'd0;
            end else if (cnt < DB_MAX) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= ST_INIT;
            prev      <= 4'd0;
            position  <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            dir       <= 1'b0;
            error     <= 1'b0;
            valid     <= 1'b0;
        end else begin
            step_up   <= 1'b0;
            step_down <= 1'b0;
            if (clear) begin
                position <= '0;
                error    <= 1'b0;
                state    <= ST_INIT;
                valid    <= 1'b0;
            end else if (enable && accept) begin
                prev <= bin;
                case (state)
                    ST_INIT: begin
                        state <= ST_TRACK;
                        valid <= 1'b1;
                    end
                    ST_TRACK: begin
                        if (delta == DELTA_UP) begin
                            position <= position + POS_ONE;
                            step_up  <= 1'b1;
                            dir      <= 1'b1;
                        end else if (delta == DELTA_DN) begin
                            position  <= position - POS_ONE;
                            step_down <= 1'b1;
                            dir       <= 1'b0;
                        end else if (delta != 4'd0) begin
                            error <= 1'b1;
                            state <= ST_FAULT;
                            valid <= 1'b0;
                        end
                    end
                    ST_FAULT: begin
                        valid <= 1'b0;
                    end
                    default: begin
                        state <= ST_INIT;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_encoder_tracker.sv
// Randomized self-checking bench for gray_encoder_tracker against a run-length/arithmetic reference model.
module tb_gray_encoder_tracker;

    localparam int W = 8;
    localparam int D = 2;
    localparam int POS_MOD = 1 << W;

    logic         clock = 1'b0;
    logic         reset_b = 1'b0;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic [3:0]   gray_in = 4'd0;
    logic [W-1:0] position;
    logic         step_up, step_down, dir, error, valid;

    int errors = 0;
    int checks = 0;
    int up_cnt = 0;
    int dn_cnt = 0;

    // reference model state: sync pipeline values, run length of the synchronized code, tracker outputs
    int m_s1, m_s2, m_run;
    int m_state;  // 0 = waiting for reference, 1 = tracking, 2 = faulted
    int m_prev, m_pos, m_dir, m_err, m_up, m_dn;

    gray_encoder_tracker #(.POS_WIDTH(W), .DEBOUNCE(D)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .enable    (enable),
        .clear     (clear),
        .gray_in   (gray_in),
        .position  (position),
        .step_up   (step_up),
        .step_down (step_down),
        .dir       (dir),
        .error     (error),
        .valid     (valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int i = 0; i < 4; i++)
            b |= ($countones((g >> i) & 15) & 1) << i;
        return b;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_run = 2;
        m_state = 0; m_prev = 0; m_pos = 0;
        m_dir = 0; m_err = 0; m_up = 0; m_dn = 0;
    endtask

    // A synchronized code is accepted on the cycle its run reaches DEBOUNCE+1 samples.
    task automatic model_edge(input int en, input int clr, input int g);
        int acc, b, d, nxt;
        acc = (m_run == D + 1);
        m_up = 0; m_dn = 0;
        if (clr != 0) begin
            m_pos = 0; m_err = 0; m_state = 0;
        end else if (en != 0 && acc != 0) begin
            b = g2b(m_s2);
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                d = (b - m_prev + 16) % 16;
                if (d == 1) begin
                    m_pos = (m_pos + 1) % POS_MOD; m_up = 1; m_dir = 1;
                end else if (d == 15) begin
                    m_pos = (m_pos + POS_MOD - 1) % POS_MOD; m_dn = 1; m_dir = 0;
                end else if (d != 0) begin
                    m_err = 1; m_state = 2;
                end
            end
            m_prev = b;
        end
        nxt = m_s1;
        m_run = (nxt == m_s2) ? ((m_run < 100) ? m_run + 1 : 100) : 1;
        m_s2 = nxt;
        m_s1 = g;
    endtask

    task automatic compare_all();
        chk("position", int'(position), m_pos);
        chk("step_up", int'(step_up), m_up);
        chk("step_down", int'(step_down), m_dn);
        chk("dir", int'(dir), m_dir);
        chk("error", int'(error), m_err);
        chk("valid", int'(valid), (m_state == 1) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge(int'(enable), int'(clear), int'(gray_in));
        #1;
        compare_all();
        if (step_up) up_cnt++;
        if (step_down) dn_cnt++;
    endtask

    task automatic hold(input int g, input int n);
        gray_in = 4'(g);
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        #2;
        model_reset();
        compare_all();
        reset_b = 1'b1;
    endtask

    initial begin
        int code, n, r;

        // reset and first re-reference
        gray_in = 4'd0;
        enable  = 1'b1;
        do_reset();
        repeat (5) tick();
        chk("init_valid", int'(valid), 1);
        chk("init_pos", int'(position), 0);
        chk("init_pulses", up_cnt + dn_cnt, 0);

        // three legal up-steps
        up_cnt = 0; dn_cnt = 0;
        hold(1, 8);
        chk("bin_1", int'(dut.bin), 1);
        hold(3, 8);
        chk("bin_2", int'(dut.bin), 2);
        hold(2, 8);
        chk("bin_3", int'(dut.bin), 3);
        chk("up3_pos", int'(position), 3);
        chk("up3_count", up_cnt, 3);
        chk("up3_dir", int'(dir), 1);

        // downward wrap from 0
        pulse_clear();
        hold(0, 8);
        chk("reref_pos", int'(position), 0);
        chk("reref_valid", int'(valid), 1);
        up_cnt = 0; dn_cnt = 0;
        hold(8, 8);
        chk("wrap_pos", int'(position), POS_MOD - 1);
        chk("wrap_dn", dn_cnt, 1);
        chk("wrap_dir", int'(dir), 0);

        // illegal jump, frozen fault, clear and recovery
        hold(0, 8);
        chk("wrap_up_pos", int'(position), 0);
        hold(3, 8);
        chk("jump_err", int'(error), 1);
        chk("jump_valid", int'(valid), 0);
        chk("jump_pos", int'(position), 0);
        up_cnt = 0; dn_cnt = 0;
        hold(1, 8);
        chk("fault_pos", int'(position), 0);
        chk("fault_pulses", up_cnt + dn_cnt, 0);
        pulse_clear();
        chk("clr_err", int'(error), 0);
        hold(3, 8);
        chk("clr_reref_pos", int'(position), 0);
        chk("clr_reref_pulses", up_cnt + dn_cnt, 0);
        hold(2, 8);
        chk("recover_pos", int'(position), 1);
        chk("recover_up", up_cnt, 1);

        // one-cycle glitch is rejected
        up_cnt = 0; dn_cnt = 0;
        hold(3, 1);
        hold(2, 8);
        chk("glitch_pos", int'(position), 1);
        chk("glitch_pulses", up_cnt + dn_cnt, 0);

        // moves while disabled are not applied later
        pulse_clear();
        hold(0, 8);
        up_cnt = 0; dn_cnt = 0;
        enable = 1'b0;
        hold(1, 8);
        enable = 1'b1;
        hold(1, 8);
        chk("dis_pos", int'(position), 0);
        chk("dis_pulses", up_cnt + dn_cnt, 0);
        hold(3, 8);
        chk("dis_err", int'(error), 1);
        chk("dis_err_pos", int'(position), 0);

        // mid-operation reset
        gray_in = 4'd0;
        do_reset();
        hold(0, 6);
        chk("rst_valid", int'(valid), 1);

        // randomized moves, holds, glitches, enable/clear/reset
        pulse_clear();
        code = 0;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)
                code = b2g((g2b(code) + (($urandom_range(0, 1) != 0) ? 1 : 15)) % 16);
            else if (r < 80)
                code = $urandom_range(0, 15);
            else if (r < 90) begin
                hold(b2g((g2b(code) + 1) % 16), 1);
            end
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) pulse_clear();
            if ($urandom_range(0, 99) == 0) do_reset();
            n = $urandom_range(1, 6);
            hold(code, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_encoder_tracker.md
Name: gray_encoder_tracker

Overview:
- Tracks the absolute position of a 4-bit Gray-coded rotary/linear encoder.
- Synchronizes and debounces the raw Gray input, then converts it to binary through a combinational Gray-to-binary stage.
- Classifies each accepted code change as step-up, step-down or illegal jump, and maintains a wrapping position counter with a fault state.
- Sits between the encoder pins and the control logic that consumes position and step events.

Parameters:
- POS_WIDTH, 8, width of the position counter (>= 4).
- DEBOUNCE, 2, consecutive stable cycles needed before a synchronized code is accepted (1..15).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_b  input  1  asynchronous active-low reset.
- enable  input  1  tracking enable; 0 freezes tracking state.
- clear  input  1  synchronous clear: position 0, error 0, state INIT.
- gray_in  input  4  raw encoder Gray code, asynchronous to clock.
- position  output  POS_WIDTH  tracked position, wraps modulo 2^POS_WIDTH.
- step_up  output  1  one-cycle pulse on +1 step.
- step_down  output  1  one-cycle pulse on -1 step.
- dir  output  1  direction of last legal step (1 = up).
- error  output  1  sticky illegal-jump flag.
- valid  output  1  high while state is TRACK.

Behaviour:
- Reset (reset_b = 0, asynchronous):
  - position = 0; step_up, step_down, dir, error, valid = 0.
  - Synchronizer flops = 0, cand = 0, cnt = 0, state = INIT.
- Synchronizer: two flops (sync1, sync2); runs regardless of enable and clear.
- Debounce:
  - If sync2 != cand: load cand <= sync2 and cnt <= 0.
  - Else: cnt increments, saturating at DEBOUNCE.
  - accept = (sync2 == cand) && (cnt == DEBOUNCE-1). It fires exactly once per stable code.
- Conversion: bin = Gray-to-binary(cand), combinational (b3 = g3, bi = b(i+1) ^ gi).
- Delta: delta = (bin - prev) mod 16, computed in 4 bits. prev holds the last accepted binary code.
- FSM, evaluated on a cycle with accept && enable:
  - INIT: prev <= bin; no step; go to TRACK.
  - TRACK:
    - delta 0: no action.
    - delta 1: position +1 (wraps from max to 0), step_up pulse, dir <= 1.
    - delta 15: position -1 (wraps from 0 to max), step_down pulse, dir <= 0.
    - Any other delta: error <= 1, position unchanged, no pulse, go to FAULT.
    - In every case prev <= bin.
  - FAULT: prev <= bin only; position frozen; stays in FAULT until clear.
- step_up and step_down are registered, high for exactly one cycle, and never both high.
- Latency: a gray_in change sampled at rising edge 1 updates position and the pulse at edge DEBOUNCE+3, provided gray_in stays stable.
- enable = 0:
  - accept is ignored; position, prev, state, dir and error hold; pulses are 0.
  - Synchronizer and debounce keep running. A code accepted while disabled is never applied retroactively.
- clear:
  - Has priority over enable and accept in the same cycle.
  - position <= 0, error <= 0, state <= INIT, pulses 0.
  - dir and prev hold. The next accept re-references prev.
- valid = (state == TRACK), registered with state.
- A glitch shorter than DEBOUNCE cycles after sync2 restarts the debounce count and produces no accept.
- Reset asserted mid-operation returns everything to reset values immediately. After release, the first accepted code is a re-reference only, never a step.

Decomposition:
- Shared package: state encoding constants ST_INIT = 2'd0, ST_TRACK = 2'd1, ST_FAULT = 2'd2; delta constants DELTA_UP = 4'd1, DELTA_DN = 4'd15.
- One sub-module, gray2bin4: purely combinational 4-bit Gray-to-binary converter, instantiated once on cand.
- FSM, debounce and counter stay in the top.

Test Plan:
- Reset then gray_in = 0000, enable = 1 → after 5 edges valid = 1, position = 0, no step pulse (re-reference only).
- From 0000, drive 0001, 0011, 0010 with each held 8 cycles → three step_up pulses, position 0→3, dir = 1, bin 1, 2, 3.
- From position 0 with code 0000, drive 1000 (bin 15) → step_down, position = 255 (POS_WIDTH = 8), dir = 0.
- Jump 0000→0011 (delta 2) → error = 1, valid = 0, position held. Further legal steps are ignored. Pulse clear → error = 0, next accept re-references, then steps count again.
- 1-cycle glitch 0000→0001→0000 with DEBOUNCE = 2 → no accept, no pulse, position unchanged.
- enable = 0 while code moves 0000→0001, then enable = 1 with the code stable → no step (no retroactive accept). A subsequent move to 0011 yields step_up from prev = 0? No: prev = 0 means delta = 2, so expect error. The bench must check exactly this.
